// File: rtl/board_lcd_formatter_pkg.sv
// Shared definitions for the 2x8 LCD board formatter: game-state codes,
// FSM state type, geometry, ASCII constants and the row-0 banner strings.
package board_fmt_pkg;

  typedef enum logic [2:0] {
    GS_READY = 3'd0,
    GS_PLAY  = 3'd1,
    GS_WIN   = 3'd2,
    GS_LOSE  = 3'd3
  } game_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } fmt_state_t;

  localparam int NUM_TILES = 16;
  localparam int NUM_COLS  = 8;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;

  // Leftmost character sits in the most significant byte.
  localparam logic [8*NUM_COLS-1:0] MSG_WIN  = "YOU WIN ";
  localparam logic [8*NUM_COLS-1:0] MSG_LOSE = "GAMEOVER";

  function automatic logic [7:0] msg_char(input logic [8*NUM_COLS-1:0] msg,
                                          input logic [2:0] col);
    return msg[8*(NUM_COLS-1-int'(col)) +: 8];
  endfunction

endpackage

// File: rtl/board_lcd_formatter_if.sv
// Character stream from the formatter to the LCD driver (valid/ready handshake).
interface board_lcd_formatter_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic [3:0] char_addr;
  logic       char_ready;

  modport master (output char_valid, output char_data, output char_addr, input char_ready);
  modport slave  (input char_valid, input char_data, input char_addr, output char_ready);
endinterface

// File: rtl/board_lcd_formatter_tile_to_ascii.sv
// Maps a 4-bit tile exponent to its display glyph: blank, '1'..'9', 'A'..'F'.
module tile_to_ascii
  import board_fmt_pkg::*;
(
  input  logic [3:0] tile,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_SPACE;
    if (tile == 4'd0) begin
      ascii = ASCII_SPACE;
    end else if (tile < 4'd10) begin
      ascii = ASCII_ZERO + {4'd0, tile};
    end else begin
      ascii = ASCII_UPPER_A + {4'd0, tile - 4'd10};
    end
  end

endmodule

// File: rtl/board_lcd_formatter.sv
// Streams a snapshot of the 4x4 board to a 2x8 LCD, one character per handshake.
// Optional FMT_CHANGE_ONLY_EN: only emit a frame when board/game_state changed.
module board_lcd_formatter
  import board_fmt_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [63:0]            board,
  input  logic [2:0]             game_state,
  board_lcd_formatter_if.master  lcd,
  output logic                   frame_done,
  output logic                   busy
);

  fmt_state_t  state_reg, state_next;
  logic [3:0]  index_reg;
  logic [63:0] snap_board_reg;
  game_state_t snap_state_reg;
  logic        trigger;
  logic        xfer;
  logic [3:0]  tiles [NUM_TILES];
  logic [7:0]  tile_char;
  logic [7:0]  char_sel;

  assign xfer = (state_reg == ST_SEND) && lcd.char_ready;

`ifdef FMT_CHANGE_ONLY_EN
  logic [63:0] last_board_reg;
  logic [2:0]  last_state_reg;
  logic        shown_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_board_reg  <= '0;
      last_state_reg  <= '0;
      shown_valid_reg <= 1'b0;
    end else if (state_reg == ST_DONE) begin
      last_board_reg  <= snap_board_reg;
      last_state_reg  <= snap_state_reg;
      shown_valid_reg <= 1'b1;
    end
  end

  assign trigger = !shown_valid_reg || (board != last_board_reg) ||
                   (game_state != last_state_reg);
`else
  assign trigger = 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (trigger) state_next = ST_SEND;
      ST_SEND: if (xfer && index_reg == 4'd15) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      index_reg      <= 4'd0;
      snap_board_reg <= '0;
      snap_state_reg <= GS_READY;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && trigger) begin
        snap_board_reg <= board;
        snap_state_reg <= game_state_t'(game_state);
        index_reg      <= 4'd0;
      end else if (xfer) begin
        index_reg <= index_reg + 4'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_tiles
    assign tiles[gi] = snap_board_reg[4*gi +: 4];
  end

  tile_to_ascii u_tile_to_ascii (
    .tile  (tiles[index_reg]),
    .ascii (tile_char)
  );

  // Banners replace only row 0; row 1 always shows tiles 8..15.
  always_comb begin
    char_sel = tile_char;
    if (!index_reg[3]) begin
      if (snap_state_reg == GS_WIN) begin
        char_sel = msg_char(MSG_WIN, index_reg[2:0]);
      end else if (snap_state_reg == GS_LOSE) begin
        char_sel = msg_char(MSG_LOSE, index_reg[2:0]);
      end
    end
  end

  assign lcd.char_valid = (state_reg == ST_SEND);
  assign lcd.char_data  = char_sel;
  assign lcd.char_addr  = index_reg;
  assign frame_done     = (state_reg == ST_DONE);
  assign busy           = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_board_lcd_formatter.sv
// Directed bench for board_lcd_formatter; expected rows are hand-written strings.
module tb_board_lcd_formatter;
  import board_fmt_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] board = '0;
  logic [2:0]  game_state = 3'd0;
  logic        frame_done, busy;
  int          n_cmp = 0;
  int          n_bad = 0;

  board_lcd_formatter_if lcd_bus ();

  board_lcd_formatter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .board      (board),
    .game_state (game_state),
    .lcd        (lcd_bus),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic restart();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Collects one frame; chars[127:64] is row 0, chars[63:0] is row 1.
  task automatic capture_frame(input bit rand_ready, input bit mutate,
                               output logic [127:0] chars, output int n_xfer,
                               output bit addr_ok, output bit stable_ok,
                               output bit done_ok, output bit timed_out);
    bit         stalled;
    bit         done_phase;
    logic [7:0] pd;
    logic [3:0] pa;
    chars = {16{8'h3F}};
    n_xfer = 0; addr_ok = 1; stable_ok = 1; done_ok = 0; timed_out = 1;
    stalled = 0; done_phase = 0; pd = '0; pa = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done_phase) begin
        done_ok = (frame_done === 1'b1) && (lcd_bus.char_valid === 1'b0) && (busy === 1'b1);
        timed_out = 0;
        break;
      end
      if (stalled && (lcd_bus.char_valid !== 1'b1 || lcd_bus.char_data !== pd ||
                      lcd_bus.char_addr !== pa))
        stable_ok = 0;
      lcd_bus.char_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 0;
      if (lcd_bus.char_valid === 1'b1) begin
        if (lcd_bus.char_ready) begin
          if (lcd_bus.char_addr !== 4'(n_xfer)) addr_ok = 0;
          chars[8*(15 - int'(lcd_bus.char_addr)) +: 8] = lcd_bus.char_data;
          n_xfer++;
          if (n_xfer == 16) done_phase = 1;
          if (mutate && n_xfer == 4) begin
            board = ~board;
            game_state = GS_LOSE;
          end
        end else begin
          stalled = 1;
          pd = lcd_bus.char_data;
          pa = lcd_bus.char_addr;
        end
      end
    end
    lcd_bus.char_ready = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (lcd_bus.char_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", lcd_bus.char_valid); end
    n_cmp++; if (lcd_bus.char_data !== 8'h20) begin n_bad++; $display("FAIL reset_data got %h want 20", lcd_bus.char_data); end
    n_cmp++; if (lcd_bus.char_addr !== 4'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", lcd_bus.char_addr); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    $display("reset: valid=%b data=%h addr=%0d done=%b busy=%b", lcd_bus.char_valid,
             lcd_bus.char_data, lcd_bus.char_addr, frame_done, busy);
  endtask

  task automatic run_frame(input string name, input logic [63:0] b, input logic [2:0] gs,
                           input logic [63:0] exp_row0, input logic [63:0] exp_row1,
                           input bit rand_ready, input bit mutate);
    logic [127:0] chars;
    int n; bit a_ok, s_ok, d_ok, t_out;
    board = b; game_state = gs;
    restart();
    capture_frame(rand_ready, mutate, chars, n, a_ok, s_ok, d_ok, t_out);
    $display("%s: row0=\"%s\" row1=\"%s\" xfers=%0d", name, chars[127:64], chars[63:0], n);
    n_cmp++; if (t_out) begin n_bad++; $display("FAIL %s_timeout got %0d transfers want 16", name, n); end
    n_cmp++; if (chars[127:64] !== exp_row0) begin n_bad++; $display("FAIL %s_row0 got %h want %h", name, chars[127:64], exp_row0); end
    n_cmp++; if (chars[63:0] !== exp_row1) begin n_bad++; $display("FAIL %s_row1 got %h want %h", name, chars[63:0], exp_row1); end
    n_cmp++; if (!a_ok) begin n_bad++; $display("FAIL %s_addr_seq got out-of-order want 0..15", name); end
    n_cmp++; if (!d_ok) begin n_bad++; $display("FAIL %s_frame_done got missing want pulse after addr15", name); end
    if (rand_ready) begin
      n_cmp++; if (!s_ok) begin n_bad++; $display("FAIL %s_stall_stable got changed want stable", name); end
    end
  endtask

  task automatic test_basic();
    run_frame("basic", 64'h0000_0000_0000_0021, GS_PLAY, "12      ", "        ", 0, 0);
  endtask

  task automatic test_hex();
    run_frame("hex", 64'h0009_0000_0000_F0A0, GS_PLAY, " A F    ", "    9   ", 0, 0);
  endtask

  task automatic test_messages();
    run_frame("win", 64'h0000_000B_1234_5678, GS_WIN, "YOU WIN ", "B       ", 0, 0);
    run_frame("lose", 64'h0000_000B_1234_5678, GS_LOSE, "GAMEOVER", "B       ", 0, 0);
    run_frame("ready", 64'h0000_000B_1234_5678, GS_READY, "87654321", "B       ", 0, 0);
    run_frame("code5", 64'h0000_000B_1234_5678, 3'd5, "87654321", "B       ", 0, 0);
  endtask

  task automatic test_backpressure();
    run_frame("bp_mutate", 64'hFEDC_BA98_7654_3210, GS_PLAY, " 1234567", "89ABCDEF", 1, 1);
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    board = 64'hFEDC_BA98_7654_3210; game_state = GS_PLAY;
    restart();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (lcd_bus.char_valid === 1'b1 && lcd_bus.char_addr === 4'd7) begin hit = 1; break; end
    end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL mid_reach_idx7 got timeout want addr 7"); end
    rst_n = 1'b0;
    #1;
    $display("mid_reset: valid=%b addr=%0d busy=%b", lcd_bus.char_valid, lcd_bus.char_addr, busy);
    n_cmp++; if (lcd_bus.char_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %b want 0", lcd_bus.char_valid); end
    n_cmp++; if (lcd_bus.char_addr !== 4'd0) begin n_bad++; $display("FAIL mid_addr got %0d want 0", lcd_bus.char_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end
    run_frame("after_mid", 64'hFEDC_BA98_7654_3210, GS_PLAY, " 1234567", "89ABCDEF", 0, 0);
  endtask

`ifdef FMT_CHANGE_ONLY_EN
  task automatic watch_idle(input string name);
    int n_valid = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (lcd_bus.char_valid === 1'b1) n_valid++;
    end
    $display("%s: valid cycles=%0d", name, n_valid);
    n_cmp++; if (n_valid != 0) begin n_bad++; $display("FAIL %s got %0d valid cycles want 0", name, n_valid); end
  endtask

  task automatic test_change_only();
    logic [127:0] chars;
    int n; bit a_ok, s_ok, d_ok, t_out;
    run_frame("co_first", 64'h0000_0000_0000_0021, GS_PLAY, "12      ", "        ", 0, 0);
    watch_idle("co_quiet1");
    board = 64'h0000_0000_0000_0031;
    capture_frame(0, 0, chars, n, a_ok, s_ok, d_ok, t_out);
    $display("co_second: row0=\"%s\" xfers=%0d", chars[127:64], n);
    n_cmp++; if (t_out || chars[127:64] !== "13      ") begin n_bad++; $display("FAIL co_second got %h want %h", chars[127:64], 64'h3133_2020_2020_2020); end
    watch_idle("co_quiet2");
  endtask
`else
  task automatic test_repeat();
    int rises[$];
    int n_done = 0;
    bit prev_valid = 0;
    board = 64'h0000_0000_0000_0021; game_state = GS_PLAY;
    restart();
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (lcd_bus.char_valid === 1'b1 && !prev_valid) rises.push_back(c);
      if (frame_done === 1'b1) n_done++;
      prev_valid = (lcd_bus.char_valid === 1'b1);
    end
    $display("repeat: starts=%0d first=%0d done_pulses=%0d", rises.size(),
             rises.size() > 0 ? rises[0] : -1, n_done);
    n_cmp++; if (rises.size() < 2) begin n_bad++; $display("FAIL repeat_starts got %0d want >=2", rises.size()); end
    else begin
      n_cmp++; if (rises[1] - rises[0] != 18) begin n_bad++; $display("FAIL repeat_period got %0d want 18", rises[1] - rises[0]); end
      n_cmp++; if (rises[0] != 1) begin n_bad++; $display("FAIL repeat_first_start got %0d want 1", rises[0]); end
    end
    n_cmp++; if (n_done != 3) begin n_bad++; $display("FAIL repeat_done_pulses got %0d want 3", n_done); end
  endtask
`endif

  initial begin
    lcd_bus.char_ready = 1'b1;
    test_reset();
    test_basic();
    test_hex();
    test_messages();
    test_backpressure();
    test_reset_mid();
`ifdef FMT_CHANGE_ONLY_EN
    test_change_only();
`else
    test_repeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_lcd_formatter.md
BOARD_LCD_FORMATTER -- requirements
Module: board_lcd_formatter

Interface
REQ-001 SHALL have ports clk (input, 1 bit, single clock domain, rising edge) and rst_n (input, 1 bit); reset is asynchronous, active-low.
REQ-002 SHALL have board (input, 64 bits): 16 tiles; tile i = board[4i+3:4i]; value is log2 of the tile (0 = empty).
REQ-003 SHALL have game_state (input, 3 bits): game status code, encoded per the shared package.
REQ-004 SHALL have char_ready (input, 1 bit): the downstream LCD driver accepts a character.
REQ-005 SHALL have char_valid (output, 1 bit): char_data/char_addr hold a valid character.
REQ-006 SHALL have char_data (output, 8 bits): ASCII code.
REQ-007 SHALL have char_addr (output, 4 bits): position; bit 3 = row (0..1), bits 2:0 = column (0..7) of the 2x8 display.
REQ-008 SHALL have frame_done (output, 1 bit): one-cycle pulse after the last character of a frame is accepted.
REQ-009 SHALL have busy (output, 1 bit): high while a frame is in progress (SEND or DONE).

Function
REQ-010 SHALL implement FSM IDLE -> SEND -> DONE -> IDLE.
REQ-011 In IDLE with a frame trigger, the block SHALL snapshot board and game_state, clear index to 0, and enter SEND on the same edge.
REQ-012 In SEND, char_valid SHALL be 1; a transfer occurs when char_valid & char_ready are both high at a clock edge.
REQ-013 While char_valid=1 and char_ready=0, char_data and char_addr SHALL remain stable.
REQ-014 Index SHALL advance by 1 per transfer, 0..15, and char_addr SHALL equal the index.
REQ-015 A transfer at index 15 SHALL move the FSM to DONE; in DONE frame_done=1 and char_valid=0 for exactly one cycle, then IDLE.
REQ-016 At full throughput (char_ready held 1), a frame SHALL take 16 SEND cycles plus 1 DONE cycle.
REQ-017 Tile-to-char mapping SHALL be: 0 -> 0x20 (space); 1..9 -> 0x31..0x39; 10..15 -> 0x41..0x46 ('A'..'F').
REQ-018 If the snapshot game_state is WIN, row 0 SHALL carry "YOU WIN " instead of tiles 0..7; row 1 SHALL still carry tiles 8..15.
REQ-019 If the snapshot game_state is LOSE, row 0 SHALL carry "GAMEOVER"; any other code SHALL show tiles on both rows.
REQ-020 Input changes during SEND/DONE SHALL NOT affect the current frame; only the snapshot is used.
REQ-021 char_ready asserted outside SEND SHALL be ignored.

Reset
REQ-022 On rst_n=0, the block SHALL immediately force: FSM=IDLE, index=0, char_valid=0, char_data=0x20, char_addr=0, frame_done=0, busy=0, snapshot cleared, shown-valid flag cleared.
REQ-023 A reset mid-frame SHALL abandon the frame; the next frame SHALL restart at index 0.

Configuration
REQ-024 With macro FMT_CHANGE_ONLY_EN defined: the trigger SHALL be high in IDLE only when the shown-valid flag is clear, or board/game_state differs from the last emitted snapshot; the last snapshot and the flag SHALL update in DONE.
REQ-025 Without FMT_CHANGE_ONLY_EN: the trigger SHALL be constantly high, so frames repeat continuously with one IDLE cycle between DONE and the next SEND; no last-snapshot registers SHALL exist.

Structure
REQ-026 Package board_fmt_pkg SHALL hold: game-state codes (READY=0, PLAY=1, WIN=2, LOSE=3), FSM state type, NUM_TILES=16, NUM_COLS=8, ASCII constants, and the WIN/LOSE message strings.
REQ-027 Sub-module tile_to_ascii (purely combinational, 4-bit in, 8-bit out) SHALL implement REQ-017.

Verification
REQ-028 Reset, then board=0x0000_0000_0000_0021, state=PLAY, char_ready=1 -> 16 chars: addr0='1'(0x31), addr1='2'(0x32), addr2..15=0x20; frame_done one cycle after the addr15 transfer.
REQ-029 Tile values 10 and 15 -> 0x41 and 0x46 at the matching addresses.
REQ-030 state=WIN, board tile8=0xB -> addr0..7 = "YOU WIN "; addr8=0x42; state=LOSE -> "GAMEOVER" on row 0.
REQ-031 char_ready toggled randomly (backpressure) -> no char lost or duplicated; data/addr stable while stalled; board changed mid-frame -> current frame unchanged.
REQ-032 rst_n pulsed low at index 7 -> char_valid drops immediately; after release, the next frame starts at addr 0.
REQ-033 FMT_CHANGE_ONLY_EN defined, constant inputs -> exactly one frame after reset; changing one tile -> exactly one more frame. Macro undefined -> frames repeat every 18 cycles with char_ready=1.
